// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and ASCII tables for the LCD status driver.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_ADDR_L1  = 8'h80;
  localparam logic [7:0] CMD_ADDR_L2  = 8'hC0;

  localparam int US_SETUP    = 1;
  localparam int US_PULSE    = 1;
  localparam int US_WAIT     = 50;
  localparam int US_WAIT_CLR = 2000;
  localparam int US_PWR      = 20000;

  typedef enum logic [2:0] {
    ST_PWR_WAIT, ST_INIT, ST_FRAME_START, ST_ADDR1, ST_LINE1, ST_ADDR2, ST_LINE2
  } lcd_state_t;

  typedef enum logic [2:0] {
    BW_IDLE, BW_SETUP, BW_PULSE, BW_WAIT, BW_DONE
  } bw_state_t;

  typedef enum logic [2:0] {
    MODE_FAST, MODE_SLW0, MODE_SLW1, MODE_REV, MODE_NORM
  } mode_t;

  localparam logic [31:0] NAME4_TBL [8] = '{
    "IDLE", "RECD", "RPAU", "PLAY", "PPAU", "----", "----", "----"
  };

  localparam logic [31:0] MODE4_TBL [5] = '{
    "FAST", "SLW0", "SLW1", "REV ", "NORM"
  };

  function automatic mode_t mode_sel(input logic fast, input logic slow_0,
                                     input logic slow_1, input logic reverse);
    if (fast)         return MODE_FAST;
    else if (slow_0)  return MODE_SLW0;
    else if (slow_1)  return MODE_SLW1;
    else if (reverse) return MODE_REV;
    else              return MODE_NORM;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Writes one byte onto the HD44780 bus: SETUP, EN pulse, then holds DATA/RS through the
// command execution wait. start is honoured only in IDLE; done pulses after WAIT.
//   state    | meaning
//   BW_IDLE  | ready for start
//   BW_SETUP | DATA/RS driven, EN low
//   BW_PULSE | EN high
//   BW_WAIT  | EN low, DATA/RS held (long wait after clear)
//   BW_DONE  | one-cycle done pulse
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int CYC_US = 1
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       rs,
  input  logic       long_wait,
  output logic       ready,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en
);

  localparam int N_SETUP    = US_SETUP * CYC_US;
  localparam int N_PULSE    = US_PULSE * CYC_US;
  localparam int N_WAIT     = US_WAIT * CYC_US;
  localparam int N_WAIT_CLR = US_WAIT_CLR * CYC_US;
  localparam int CW         = $clog2(N_WAIT_CLR + 1);

  bw_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    data_q, data_n;
  logic          rs_q, rs_n, long_q, long_n;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state  <= BW_IDLE;
      cnt    <= '0;
      data_q <= '0;
      rs_q   <= 1'b0;
      long_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      data_q <= data_n;
      rs_q   <= rs_n;
      long_q <= long_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    data_n  = data_q;
    rs_n    = rs_q;
    long_n  = long_q;
    case (state)
      BW_IDLE: begin
        // The bus only ever changes here, on the way into SETUP.
        if (start) begin
          state_n = BW_SETUP;
          cnt_n   = CW'(N_SETUP - 1);
          data_n  = data;
          rs_n    = rs;
          long_n  = long_wait;
        end
      end
      BW_SETUP: begin
        if (cnt == '0) begin
          state_n = BW_PULSE;
          cnt_n   = CW'(N_PULSE - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      BW_PULSE: begin
        if (cnt == '0) begin
          state_n = BW_WAIT;
          cnt_n   = long_q ? CW'(N_WAIT_CLR - 1) : CW'(N_WAIT - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      BW_WAIT: begin
        if (cnt == '0) state_n = BW_DONE;
        else           cnt_n   = cnt - CW'(1);
      end
      BW_DONE: state_n = BW_IDLE;
      default: state_n = BW_IDLE;
    endcase
  end

  assign ready    = (state == BW_IDLE);
  assign done     = (state == BW_DONE);
  assign lcd_en   = (state == BW_PULSE);
  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;

endmodule

// File: rtl/lcd_status_driver.sv
// Renders recorder status onto a 16x2 HD44780 panel: power-on wait, init, then an endless
// refresh of two lines built from a per-frame input snapshot.
//   state          | meaning
//   ST_PWR_WAIT    | panel power-on delay
//   ST_INIT        | function set, display on, clear, entry mode
//   ST_FRAME_START | snapshot status inputs
//   ST_ADDR1       | DDRAM address line 1
//   ST_LINE1       | 16 chars of line 1
//   ST_ADDR2       | DDRAM address line 2
//   ST_LINE2       | 16 chars of line 2
module lcd_status_driver
  import lcd_pkg::*;
#(
  parameter int CLK_HZ = 12000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_state,
  input  logic [5:0] i_time,
  input  logic [2:0] i_speed,
  input  logic       i_fast,
  input  logic       i_slow_0,
  input  logic       i_slow_1,
  input  logic       i_reverse,
  output logic [7:0] o_LCD_DATA,
  output logic       o_LCD_EN,
  output logic       o_LCD_RS,
  output logic       o_LCD_RW,
  output logic       o_LCD_ON,
  output logic       o_LCD_BLON,
  output logic       o_init_done
);

  localparam int CYC_US = CLK_HZ / 1000000;
  localparam int N_PWR  = US_PWR * CYC_US;
  localparam int PW     = $clog2(N_PWR);

  lcd_state_t    state, state_n;
  logic [PW-1:0] pwr_cnt, pwr_n;
  logic [3:0]    idx, idx_n;
  logic          pending, pend_n;
  logic          init_done_q, done_n;

  logic [2:0]    snap_state;
  logic [5:0]    snap_time;
  logic [2:0]    snap_speed;
  mode_t         snap_mode;

  logic          wr_start, wr_ready, wr_done, wr_rs, wr_long;
  logic [7:0]    wr_data;
  logic [5:0]    tens, ones;
  logic [127:0]  line1, line2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_PWR_WAIT;
      pwr_cnt     <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      init_done_q <= 1'b0;
      snap_state  <= '0;
      snap_time   <= '0;
      snap_speed  <= '0;
      snap_mode   <= MODE_NORM;
    end else begin
      state       <= state_n;
      pwr_cnt     <= pwr_n;
      idx         <= idx_n;
      pending     <= pend_n;
      init_done_q <= done_n;
      if (state == ST_FRAME_START) begin
        snap_state <= i_state;
        snap_time  <= i_time;
        snap_speed <= i_speed;
        snap_mode  <= mode_sel(i_fast, i_slow_0, i_slow_1, i_reverse);
      end
    end
  end

  always_comb begin
    state_n  = state;
    pwr_n    = pwr_cnt;
    idx_n    = idx;
    pend_n   = pending;
    done_n   = init_done_q;
    wr_start = 1'b0;
    case (state)
      ST_PWR_WAIT: begin
        if (pwr_cnt == PW'(N_PWR - 1)) begin
          state_n = ST_INIT;
          pwr_n   = '0;
        end else begin
          pwr_n = pwr_cnt + PW'(1);
        end
      end
      ST_FRAME_START: state_n = ST_ADDR1;
      default: begin
        // One byte in flight at a time; advance only when the writer reports done.
        if (!pending) begin
          wr_start = wr_ready;
          pend_n   = wr_ready;
        end else if (wr_done) begin
          pend_n = 1'b0;
          case (state)
            ST_INIT: begin
              if (idx == 4'd3) begin
                state_n = ST_FRAME_START;
                idx_n   = '0;
                done_n  = 1'b1;
              end else begin
                idx_n = idx + 4'd1;
              end
            end
            ST_ADDR1: state_n = ST_LINE1;
            ST_LINE1: begin
              if (idx == 4'd15) begin
                state_n = ST_ADDR2;
                idx_n   = '0;
              end else begin
                idx_n = idx + 4'd1;
              end
            end
            ST_ADDR2: state_n = ST_LINE2;
            ST_LINE2: begin
              if (idx == 4'd15) begin
                state_n = ST_FRAME_START;
                idx_n   = '0;
              end else begin
                idx_n = idx + 4'd1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  assign tens  = snap_time / 6'd10;
  assign ones  = snap_time % 6'd10;
  assign line1 = {"ST:", NAME4_TBL[snap_state], " T:",
                  8'h30 + {2'b00, tens}, 8'h30 + {2'b00, ones}, "s   "};
  assign line2 = {"SPD:", 8'h31 + {5'b00000, snap_speed}, " MODE:",
                  MODE4_TBL[snap_mode], " "};

  always_comb begin
    wr_data = CMD_ADDR_L1;
    wr_rs   = 1'b0;
    case (state)
      ST_INIT: begin
        case (idx[1:0])
          2'd0:    wr_data = CMD_FUNC_SET;
          2'd1:    wr_data = CMD_DISP_ON;
          2'd2:    wr_data = CMD_CLEAR;
          default: wr_data = CMD_ENTRY;
        endcase
      end
      ST_ADDR1: wr_data = CMD_ADDR_L1;
      ST_LINE1: begin
        wr_data = line1[{~idx, 3'b000} +: 8];
        wr_rs   = 1'b1;
      end
      ST_ADDR2: wr_data = CMD_ADDR_L2;
      ST_LINE2: begin
        wr_data = line2[{~idx, 3'b000} +: 8];
        wr_rs   = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_long = (wr_data == CMD_CLEAR) && !wr_rs;

  lcd_byte_writer #(
    .CYC_US(CYC_US)
  ) u_writer (
    .clk_sys  (i_clk),
    .rst      (i_rst),
    .start    (wr_start),
    .data     (wr_data),
    .rs       (wr_rs),
    .long_wait(wr_long),
    .ready    (wr_ready),
    .done     (wr_done),
    .lcd_data (o_LCD_DATA),
    .lcd_rs   (o_LCD_RS),
    .lcd_en   (o_LCD_EN)
  );

  assign o_LCD_RW    = 1'b0;
  assign o_LCD_ON    = 1'b1;
  assign o_LCD_BLON  = 1'b1;
  assign o_init_done = init_done_q;

endmodule

// File: tb/tb_lcd_status_driver.sv
// Scoreboard bench for lcd_status_driver: expected bus bytes are queued from a string-level
// model of each frame; a monitor on the LCD bus pops and compares every EN pulse.
module tb_lcd_status_driver;

  localparam int CLK_HZ = 1000000;
  localparam int CYC_US = CLK_HZ / 1000000;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [2:0] i_state;
  logic [5:0] i_time;
  logic [2:0] i_speed;
  logic       i_fast, i_slow_0, i_slow_1, i_reverse;
  logic [7:0] o_LCD_DATA;
  logic       o_LCD_EN, o_LCD_RS, o_LCD_RW, o_LCD_ON, o_LCD_BLON, o_init_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int addr1_cnt = 0;
  logic [9:0] exp_q[$];   // {init_done, rs, data}

  lcd_status_driver #(.CLK_HZ(CLK_HZ)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_state(i_state), .i_time(i_time), .i_speed(i_speed),
    .i_fast(i_fast), .i_slow_0(i_slow_0), .i_slow_1(i_slow_1), .i_reverse(i_reverse),
    .o_LCD_DATA(o_LCD_DATA), .o_LCD_EN(o_LCD_EN), .o_LCD_RS(o_LCD_RS), .o_LCD_RW(o_LCD_RW),
    .o_LCD_ON(o_LCD_ON), .o_LCD_BLON(o_LCD_BLON), .o_init_done(o_init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 'h%0h, required 'h%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  function automatic string name4(input int code);
    case (code)
      0: return "IDLE";
      1: return "RECD";
      2: return "RPAU";
      3: return "PLAY";
      4: return "PPAU";
      default: return "----";
    endcase
  endfunction

  function automatic string mode4(input bit f, input bit s0, input bit s1, input bit r);
    if (f) return "FAST";
    if (s0) return "SLW0";
    if (s1) return "SLW1";
    if (r) return "REV ";
    return "NORM";
  endfunction

  task automatic push_init();
    exp_q.push_back({2'b00, 8'h38});
    exp_q.push_back({2'b00, 8'h0C});
    exp_q.push_back({2'b00, 8'h01});
    exp_q.push_back({2'b00, 8'h06});
  endtask

  task automatic push_frame();
    string l1, l2;
    l1 = $sformatf("ST:%s T:%0d%0ds   ", name4(int'(i_state)), int'(i_time) / 10,
                   int'(i_time) % 10);
    l2 = $sformatf("SPD:%0d MODE:%s ", int'(i_speed) + 1,
                   mode4(i_fast, i_slow_0, i_slow_1, i_reverse));
    exp_q.push_back({2'b10, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({2'b11, l1[i]});
    exp_q.push_back({2'b10, 8'hC0});
    for (int i = 0; i < 16; i++) exp_q.push_back({2'b11, l2[i]});
  endtask

  task automatic rand_inputs();
    i_state   = 3'($urandom_range(0, 7));
    i_time    = 6'($urandom_range(0, 63));
    i_speed   = 3'($urandom_range(0, 7));
    i_fast    = 1'($urandom_range(0, 3) == 0);
    i_slow_0  = 1'($urandom_range(0, 2) == 0);
    i_slow_1  = 1'($urandom_range(0, 1));
    i_reverse = 1'($urandom_range(0, 1));
  endtask

  task automatic measure_pwr();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!o_LCD_EN && n < 25000);
    // After release: 20000 us of power wait plus at least the 1 us setup of the first byte.
    check_range("pwr_wait_cycles", n, 20000 + CYC_US, 20000 + CYC_US + 8);
  endtask

  // Bus monitor, sampled on the falling edge.
  logic [7:0] prev_d, cap_d;
  logic       prev_rs, cap_rs;
  bit         in_pulse = 0, have_fall = 0, prev_long = 0;
  int         hi_cnt = 0, fall_cyc = 0;
  logic [9:0] e;

  always @(negedge clk) begin
    if (i_rst) begin
      in_pulse  = 0;
      have_fall = 0;
    end else if (o_LCD_EN && !in_pulse) begin
      in_pulse = 1;
      hi_cnt   = 1;
      cap_d    = o_LCD_DATA;
      cap_rs   = o_LCD_RS;
      check("setup_to_en_stable", int'({o_LCD_RS, o_LCD_DATA}), int'({prev_rs, prev_d}));
      if (have_fall) begin
        if (prev_long) check_range("gap_after_clear", cyc - fall_cyc,
                                   (2000 + 1) * CYC_US, (2000 + 1) * CYC_US + 8);
        else           check_range("gap_after_byte", cyc - fall_cyc,
                                   (50 + 1) * CYC_US, (50 + 1) * CYC_US + 8);
      end
      check("rw_on_blon", int'({o_LCD_RW, o_LCD_ON, o_LCD_BLON}), 3'b011);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL byte: got data 'h%0h rs %0b, required no byte", o_LCD_DATA, o_LCD_RS);
      end else begin
        e = exp_q.pop_front();
        check("byte{init_done,rs,data}", int'({o_init_done, o_LCD_RS, o_LCD_DATA}), int'(e));
      end
      if (o_LCD_DATA == 8'h80 && !o_LCD_RS) addr1_cnt++;
      prev_long = (o_LCD_DATA == 8'h01) && !o_LCD_RS;
    end else if (o_LCD_EN) begin
      hi_cnt++;
      check("data_stable_en_high", int'({o_LCD_RS, o_LCD_DATA}), int'({cap_rs, cap_d}));
    end else if (in_pulse) begin
      in_pulse = 0;
      check("en_high_cycles", hi_cnt, CYC_US);
      check("data_hold_after_en", int'({o_LCD_RS, o_LCD_DATA}), int'({cap_rs, cap_d}));
      fall_cyc  = cyc;
      have_fall = 1;
    end
    prev_d  = o_LCD_DATA;
    prev_rs = o_LCD_RS;
  end

  initial begin
    #(10 * 95000);
    vectors++;
    miscompares++;
    $display("FAIL watchdog: reached cycle %0d, required completion earlier", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    i_rst = 1'b1;
    i_state = 3'd3; i_time = 6'd7; i_speed = 3'd7;
    i_fast = 1'b1; i_slow_0 = 1'b1; i_slow_1 = 1'b0; i_reverse = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_en", int'(o_LCD_EN), 0);
    check("rst_rs", int'(o_LCD_RS), 0);
    check("rst_data", int'(o_LCD_DATA), 0);
    check("rst_rw", int'(o_LCD_RW), 0);
    check("rst_on", int'(o_LCD_ON), 1);
    check("rst_blon", int'(o_LCD_BLON), 1);
    check("rst_init_done", int'(o_init_done), 0);

    push_init();
    push_frame();
    i_rst = 1'b0;
    measure_pwr();

    wait (addr1_cnt >= 1);
    i_state = 3'd6; i_time = 6'd12; i_speed = 3'd2;
    i_fast = 1'b0; i_slow_0 = 1'b0; i_slow_1 = 1'b0; i_reverse = 1'b1;
    push_frame();

    // Changes during this frame's line 1 must only show up in the next frame.
    wait (addr1_cnt >= 2);
    i_time = 6'd45;
    push_frame();

    for (int k = 3; k <= 5; k++) begin
      wait (addr1_cnt >= k);
      rand_inputs();
      push_frame();
    end

    wait (addr1_cnt >= 6);
    do begin
      @(posedge clk); #1;
    end while (!o_LCD_EN);
    i_rst = 1'b1;
    @(posedge clk); #1;
    check("midbyte_rst_en", int'(o_LCD_EN), 0);
    check("midbyte_rst_init_done", int'(o_init_done), 0);
    check("midbyte_rst_data", int'(o_LCD_DATA), 0);
    check("midbyte_rst_rs", int'(o_LCD_RS), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rand_inputs();
    push_init();
    push_frame();
    i_rst = 1'b0;
    measure_pwr();

    wait (addr1_cnt >= 7);
    rand_inputs();
    push_frame();

    wait (exp_q.size() == 0);
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_status_driver.md
LCD_STATUS_DRIVER -- requirements
Module: lcd_status_driver

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12000000, meaning i_clk frequency, from which all LCD delays are derived as cycles = CLK_HZ/1000000 * microseconds.
REQ-002 SHALL have port i_clk  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_state  input  3  recorder top state code.
REQ-005 SHALL have port i_time  input  6  elapsed seconds, 0..63.
REQ-006 SHALL have port i_speed  input  3  speed selector; the displayed digit is i_speed+1.
REQ-007 SHALL have ports i_fast, i_slow_0, i_slow_1, i_reverse  input  1 each  mode switches.
REQ-008 SHALL have ports o_LCD_DATA  output  8, o_LCD_EN/o_LCD_RS/o_LCD_RW/o_LCD_ON/o_LCD_BLON  output  1 each; these drive the HD44780-type 16x2 panel.
REQ-009 SHALL have port o_init_done  output  1  high once the init sequence completes; stays high until reset.

Function
REQ-010 SHALL drive o_LCD_RW=0, o_LCD_ON=1 and o_LCD_BLON=1 at all times; the block is write-only.
REQ-011 SHALL write each byte in three phases: SETUP (RS/DATA valid, EN=0, 1 us), PULSE (EN=1, 1 us), WAIT (EN=0, DATA/RS held, 50 us; 2000 us after the clear command 0x01).
REQ-012 SHALL change o_LCD_DATA and o_LCD_RS only in SETUP, never while EN=1.
REQ-013 SHALL follow this top FSM: PWR_WAIT (20000 us) -> INIT -> FRAME_START -> ADDR1 -> LINE1 -> ADDR2 -> LINE2 -> FRAME_START, repeating forever.
REQ-014 SHALL in INIT write commands 0x38, 0x0C, 0x01, 0x06 in order with RS=0, then assert o_init_done on the cycle it enters FRAME_START.
REQ-015 SHALL in FRAME_START take a one-cycle snapshot of all status inputs; the whole frame is rendered from this snapshot (no tearing).
REQ-016 SHALL write address command 0x80 before line 1 and 0xC0 before line 2 (RS=0), then 16 characters per line (RS=1).
REQ-017 SHALL render line 1 as "ST:" + name4 + " T:" + tens + ones + "s" + three spaces (16 chars).
REQ-018 SHALL map the state code to name4 as 0 "IDLE", 1 "RECD", 2 "RPAU", 3 "PLAY", 4 "PPAU", and 5..7 "----".
REQ-019 SHALL render time as two ASCII decimal digits with tens = i_time/10 and ones = i_time%10, keeping the leading zero (7 -> "07", 63 -> "63").
REQ-020 SHALL render line 2 as "SPD:" + digit + " MODE:" + mode4 + one space, where the digit is ASCII '1'..'8' (i_speed 7 -> '8').
REQ-021 SHALL select mode4 with priority fast "FAST" > slow_0 "SLW0" > slow_1 "SLW1" > reverse "REV " > otherwise "NORM".
REQ-022 SHALL ignore input changes mid-frame; they appear in the next frame.

Reset
REQ-023 SHALL, on the cycle after i_rst is sampled high, set o_LCD_DATA=0x00, EN=0, RS=0, RW=0, ON=1, BLON=1, o_init_done=0, clear all counters, and put the FSM in PWR_WAIT.
REQ-024 SHALL, when reset is asserted mid-byte (including EN=1), drop EN the next cycle and redo the full power-on wait and init after release.

Structure
REQ-025 SHALL place in shared package lcd_pkg the LCD command constants (0x38, 0x0C, 0x01, 0x06, 0x80, 0xC0), the top-FSM state enum, and the name4/mode4 ASCII tables.
REQ-026 SHALL use one sub-module, lcd_byte_writer, which implements REQ-011/012 with a start/done handshake: start is accepted only while idle, and done pulses one cycle after WAIT ends.

Verification (CLK_HZ=1000000 to shorten sim)
REQ-027 SHALL cover: reset then release -> EN low for 20000 cycles, then bytes 38,0C,01,06 with RS=0, gap after 01 >= 2000 cycles, o_init_done rises.
REQ-028 SHALL cover: state=3, time=7 -> line 1 bytes "ST:PLAY T:07s   " after 0x80.
REQ-029 SHALL cover: speed=7, fast=1, slow_0=1 -> line 2 "SPD:8 MODE:FAST ".
REQ-030 SHALL cover: time changes 12->45 during LINE1 -> current frame shows "12", next frame shows "45".
REQ-031 SHALL cover: reset pulsed while EN=1 -> EN=0 next cycle, o_init_done=0, and the full init sequence repeats.
REQ-032 SHALL check every byte with a bench monitor: DATA/RS stable for the whole EN-high window, EN high for exactly 1 us, and state=6 displayed as "----".
